// File: rtl/pim_matrix_stream_loader.sv
// Stream front end for the PIM matrix-multiply controller: loads A and B as
// row-major word streams, launches the controller, captures the product and
// drains it back out as a row-major word stream with start-to-result latency.
module pim_matrix_stream_loader #(
    parameter int WIDTH       = 16,
    parameter int MATRIX_SIZE = 4,
    parameter int LAT_WIDTH   = 32
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [WIDTH-1:0]                               in_data,
    output logic [MATRIX_SIZE*MATRIX_SIZE-1:0][WIDTH-1:0]  matrix_A,
    output logic [MATRIX_SIZE*MATRIX_SIZE-1:0][WIDTH-1:0]  matrix_B,
    output logic                                           start,
    input  logic [MATRIX_SIZE*MATRIX_SIZE-1:0][WIDTH-1:0]  result,
    input  logic                                           result_ready,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [WIDTH-1:0]                               out_data,
    output logic                                           out_last,
    output logic                                           busy,
    output logic [LAT_WIDTH-1:0]                           latency_cycles
);

    localparam int NN = MATRIX_SIZE * MATRIX_SIZE;
    localparam int CW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NN - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        DRAIN
    } state_t;

    state_t                          state, state_nxt;
    logic [CW-1:0]                   cnt;
    logic [LAT_WIDTH-1:0]            lat_cnt;
    logic [NN-1:0][WIDTH-1:0]        res_buf;
    logic                            cnt_at_last;

    assign cnt_at_last = (cnt == CNT_LAST);

    // State register; reset drops straight back to IDLE from anywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        start     = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: state_nxt = LOAD_A;
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && cnt_at_last) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && cnt_at_last) state_nxt = START;
            end
            START: begin
                start     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (result_ready) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = res_buf[cnt];
                out_last  = cnt_at_last;
                if (out_ready && cnt_at_last) state_nxt = LOAD_A;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Element counter plus operand writes and drain advance; a reset mid-load
    // or mid-drain discards all progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            matrix_A <= '0;
            matrix_B <= '0;
        end else begin
            case (state)
                LOAD_A: if (in_valid) begin
                    matrix_A[cnt] <= in_data;
                    cnt           <= cnt_at_last ? '0 : cnt + CW'(1);
                end
                LOAD_B: if (in_valid) begin
                    matrix_B[cnt] <= in_data;
                    cnt           <= cnt_at_last ? '0 : cnt + CW'(1);
                end
                DRAIN: if (out_ready) begin
                    cnt <= cnt_at_last ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Latency measurement and result capture; result_ready only matters in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt        <= '0;
            latency_cycles <= '0;
            res_buf        <= '0;
        end else begin
            case (state)
                START: lat_cnt <= '0;
                WAIT: begin
                    if (!(&lat_cnt)) lat_cnt <= lat_cnt + LAT_WIDTH'(1);
                    if (result_ready) begin
                        res_buf        <= result;
                        latency_cycles <= (&lat_cnt) ? lat_cnt : lat_cnt + LAT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pim_matrix_stream_loader.sv
// Scoreboard bench for pim_matrix_stream_loader: stimulus pushes expected
// output words, a negedge monitor pops and compares on every output handshake.
module tb_pim_matrix_stream_loader;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int NN = N * N;
    localparam int LW = 32;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [W-1:0]            in_data;
    logic [NN-1:0][W-1:0]    matrix_A;
    logic [NN-1:0][W-1:0]    matrix_B;
    logic                    start;
    logic [NN-1:0][W-1:0]    result;
    logic                    result_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [W-1:0]            out_data;
    logic                    out_last;
    logic                    busy;
    logic [LW-1:0]           latency_cycles;

    pim_matrix_stream_loader #(.WIDTH(W), .MATRIX_SIZE(N), .LAT_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .matrix_A(matrix_A), .matrix_B(matrix_B), .start(start),
        .result(result), .result_ready(result_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .latency_cycles(latency_cycles)
    );

    int checks = 0;
    int errors = 0;
    int starts = 0;
    bit stall_mode = 0;
    logic [W:0] sb[$];

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // out_ready driver: all-ones, or the 1,0,0 repeating stall pattern
    initial begin
        int ph = 0;
        out_ready = 1;
        forever begin
            @(posedge clk); #1;
            out_ready = stall_mode ? (ph % 3 == 0) : 1'b1;
            ph++;
        end
    end

    // start pulse counter
    always @(negedge clk) if (start === 1'b1) starts++;

    // monitor: pop on handshake, check stability while stalled
    initial begin
        logic [W:0] e;
        logic       stalled = 0;
        logic [W-1:0] hd;
        logic       hl;
        forever begin
            @(negedge clk);
            if (!rst_n) stalled = 0;
            else begin
                if (stalled && out_valid) begin
                    chk("stall_data", out_data, hd);
                    chk("stall_last", out_last, hl);
                end else if (stalled) chk("stall_valid", out_valid, 1);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) chk("unexpected_out", out_valid, 0);
                    else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e[W-1:0]);
                        chk("out_last", out_last, e[W]);
                    end
                end
                stalled = out_valid && !out_ready;
                hd = out_data;
                hl = out_last;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // stream n words of v into the loader, optional idle gap before each word
    task automatic load(input logic [NN-1:0][W-1:0] v, input int n, input bit gap, input bit noise);
        for (int k = 0; k < n; k++) begin
            if (gap) begin
                in_valid = 0;
                @(posedge clk); #1;
            end
            in_valid = 1;
            in_data  = v[k];
            if (noise && k == 5) begin
                result_ready = 1;
                result = '1;
            end
            @(negedge clk);
            for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
            if (!in_ready) chk("in_ready_wait", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 0;
            result_ready = 0;
        end
    endtask

    task automatic do_op(input logic [NN-1:0][W-1:0] a, input logic [NN-1:0][W-1:0] b,
                         input logic [NN-1:0][W-1:0] r, input bit gap, input bit stall,
                         input int dly, input bit noise);
        int n;
        stall_mode = stall;
        starts = 0;
        load(a, NN, gap, 0);
        load(b, NN, gap, noise);
        chk("start_after_last_b", start, 1);
        chk("busy_start", busy, 1);
        chk("in_ready_start", in_ready, 0);
        for (int k = 0; k < NN; k++) begin
            chk($sformatf("matrix_A[%0d]", k), matrix_A[k], a[k]);
            chk($sformatf("matrix_B[%0d]", k), matrix_B[k], b[k]);
        end
        for (int k = 0; k < NN; k++) sb.push_back({(k == NN - 1), r[k]});
        repeat (dly) @(posedge clk);
        #1;
        chk("no_out_in_wait", out_valid, 0);
        result_ready = 1;
        result = r;
        @(posedge clk); #1;
        result_ready = 0;
        result = '0;
        chk("out_valid_after_capture", out_valid, 1);
        chk("latency", latency_cycles, dly);
        if (noise) begin
            repeat (3) @(posedge clk);
            #1;
            result_ready = 1;
            result = '1;
            @(posedge clk); #1;
            result_ready = 0;
            result = '0;
        end
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", sb.size(), 0);
        chk("back_to_load_a", in_ready, 1);
        chk("out_valid_after_drain", out_valid, 0);
        chk("latency_held", latency_cycles, dly);
        chk("start_pulses", starts, 1);
        stall_mode = 0;
    endtask

    logic [NN-1:0][W-1:0] ma, mb, mr, mz;

    initial begin
        rst_n = 0; in_valid = 0; in_data = 0; result = '0; result_ready = 0;
        mz = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_start", start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_latency", latency_cycles, 0);
        chk("rst_matrix_A", (matrix_A == mz), 1);
        chk("rst_matrix_B", (matrix_B == mz), 1);
        @(posedge clk); #3;
        rst_n = 1;
        #1;
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
        chk("load_a_busy", busy, 1);
        chk("load_a_in_ready", in_ready, 1);

        // 1) identity x 1..16, result = B, latency 5
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i*N+j] = (i == j) ? 16'd1 : 16'd0;
                mb[i*N+j] = 16'(i*N + j + 1);
            end
        do_op(ma, mb, mb, 0, 0, 5, 0);
        // 2) same op under 1,0,0 output backpressure
        do_op(ma, mb, mb, 0, 1, 5, 0);
        // 3) input gaps, distinct operands
        for (int k = 0; k < NN; k++) begin
            ma[k] = 16'(k * 3 + 16'h0700);
            mb[k] = 16'(16'h8100 + k);
            mr[k] = 16'(16'hA000 + k * 17);
        end
        do_op(ma, mb, mr, 1, 0, 3, 0);
        // 4) stray result_ready in LOAD_B and DRAIN, with stalls
        for (int k = 0; k < NN; k++) mr[k] = 16'(16'h5A00 ^ (k << 4));
        do_op(ma, mb, mr, 0, 1, 7, 1);
        // 5) reset after 7 A words
        load(ma, 7, 0, 0);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_latency", latency_cycles, 0);
        chk("mid_rst_matrix_A", (matrix_A == mz), 1);
        chk("mid_rst_matrix_B", (matrix_B == mz), 1);
        chk("mid_rst_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1;
        #1;
        chk("idle_after_rst", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("load_a_after_rst", in_ready, 1);
        for (int k = 0; k < NN; k++) begin
            ma[k] = 16'(16'hC000 + k);
            mb[k] = 16'(16'h0F00 - k);
            mr[k] = 16'(16'h1234 + k * 257);
        end
        do_op(ma, mb, mr, 0, 0, 4, 0);
        // 6) result_ready in first WAIT cycle
        for (int k = 0; k < NN; k++) mr[k] = 16'(16'hFFF0 - k * 5);
        do_op(ma, mb, mr, 0, 0, 1, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
